cpu_bus_controller: RTL and testbench

Address decoder and bus responder sitting directly downstream of the `cpu` core, between it and the console's memory map. Accepts one CPU read or write at a time and routes it by address to internal work RAM (2 KiB, mirrored), the PPU register port, or the cartridge port. It then returns read data or a write acknowledge on a single-cycle valid pulse. It also provides NES-style open-bus behaviour and a timeout so a silent external port can never hang the CPU.

---
 rtl/cpu_bus_controller.sv | 179 +++++++++++++++++
 tb/tb_cpu_bus_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_controller.sv
// CPU-side address decoder and bus responder: routes one access at a time to mirrored
// work RAM, the PPU register port, an IO stub or the cartridge port, with open-bus and timeout.
module cpu_bus_controller #(
    parameter int RAM_ADDRESS_BITS = 11,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [15:0] cpu_address_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_read_i,
    input  logic        cpu_write_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic [2:0]  ppu_address_o,
    output logic [7:0]  ppu_data_o,
    output logic        ppu_write_o,
    output logic        ppu_request_o,
    input  logic [7:0]  ppu_data_i,
    input  logic        ppu_ack_i,
    output logic [15:0] cart_address_o,
    output logic [7:0]  cart_data_o,
    output logic        cart_write_o,
    output logic        cart_request_o,
    input  logic [7:0]  cart_data_i,
    input  logic        cart_ack_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RAM, S_IO, S_EXT_WAIT, S_RESPOND} state_e;
    typedef enum logic [1:0] {D_RAM, D_PPU, D_IO, D_CART} dest_e;

    function automatic dest_e decode(input logic [15:0] a);
        if (a[15:13] == 3'b000)       return D_RAM;
        else if (a[15:13] == 3'b001)  return D_PPU;
        else if (a[15:5] == 11'h200)  return D_IO;
        else                          return D_CART;
    endfunction

    state_e         state_q, state_d;
    logic           armed_q, armed_d;
    logic [15:0]    addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           write_q, write_d;
    logic           ppu_req_q, ppu_req_d;
    logic           cart_req_q, cart_req_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     resp_data_q, resp_data_d;
    logic [7:0]     cpu_data_q, cpu_data_d;
    logic           valid_q, valid_d;
    logic [7:0]     open_bus_q, open_bus_d;

    logic [7:0]     ram_q [2**RAM_ADDRESS_BITS];
    logic [7:0]     ram_rdata_q;
    logic [RAM_ADDRESS_BITS-1:0] ram_index;
    logic           req_any, ext_ack;
    logic [7:0]     ext_rdata, read_value, response;

    assign ram_index  = addr_q[RAM_ADDRESS_BITS-1:0];
    assign req_any    = cpu_read_i | cpu_write_i;
    assign ext_ack    = ppu_req_q ? ppu_ack_i : cart_ack_i;
    assign ext_rdata  = ppu_req_q ? ppu_data_i : cart_data_i;
    assign read_value = (decode(addr_q) == D_RAM) ? ram_rdata_q : resp_data_q;
    assign response   = write_q ? wdata_q : read_value;

    // Work RAM is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        if (state_q == S_RAM) begin
            if (write_q) ram_q[ram_index] <= wdata_q;
            ram_rdata_q <= ram_q[ram_index];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            ppu_req_q   <= 1'b0;
            cart_req_q  <= 1'b0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            cpu_data_q  <= '0;
            valid_q     <= 1'b0;
            open_bus_q  <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            ppu_req_q   <= ppu_req_d;
            cart_req_q  <= cart_req_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            cpu_data_q  <= cpu_data_d;
            valid_q     <= valid_d;
            open_bus_q  <= open_bus_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        ppu_req_d   = ppu_req_q;
        cart_req_d  = cart_req_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        cpu_data_d  = cpu_data_q;
        valid_d     = 1'b0;
        open_bus_d  = open_bus_q;

        // Re-arm only after seeing both request lines low, so a held request runs once.
        if (!req_any) armed_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (armed_q && req_any) begin
                    armed_d = 1'b0;
                    addr_d  = cpu_address_i;
                    wdata_d = cpu_data_i;
                    write_d = cpu_write_i;
                    cnt_d   = '0;
                    unique case (decode(cpu_address_i))
                        D_RAM:  state_d = S_RAM;
                        D_IO:   state_d = S_IO;
                        D_PPU:  begin state_d = S_EXT_WAIT; ppu_req_d  = 1'b1; end
                        D_CART: begin state_d = S_EXT_WAIT; cart_req_d = 1'b1; end
                    endcase
                end
            end
            S_RAM: state_d = S_RESPOND;
            S_IO: begin
                resp_data_d = open_bus_q;
                state_d     = S_RESPOND;
            end
            S_EXT_WAIT: begin
                // An ack on the final timeout cycle takes priority over the timeout.
                if (ext_ack) begin
                    resp_data_d = ext_rdata;
                    ppu_req_d   = 1'b0;
                    cart_req_d  = 1'b0;
                    state_d     = S_RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    resp_data_d = open_bus_q;
                    ppu_req_d   = 1'b0;
                    cart_req_d  = 1'b0;
                    state_d     = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESPOND: begin
                cpu_data_d = response;
                open_bus_d = response;
                valid_d    = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_data_o       = cpu_data_q;
    assign cpu_data_valid_o = valid_q;
    assign ppu_address_o    = addr_q[2:0];
    assign ppu_data_o       = wdata_q;
    assign ppu_write_o      = ppu_req_q & write_q;
    assign ppu_request_o    = ppu_req_q;
    assign cart_address_o   = addr_q;
    assign cart_data_o      = wdata_q;
    assign cart_write_o     = cart_req_q & write_q;
    assign cart_request_o   = cart_req_q;
endmodule

// File: tb/tb_cpu_bus_controller.sv
// Directed bench for cpu_bus_controller: RAM mirror, PPU/cart handshakes, timeout,
// IO stub, held-request single service and mid-access reset.
module tb_cpu_bus_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_read, cpu_write;
    logic [7:0]  cpu_data_o;
    logic        cpu_data_valid_o;
    logic [2:0]  ppu_address_o;
    logic [7:0]  ppu_data_o;
    logic        ppu_write_o, ppu_request_o;
    logic [7:0]  ppu_data;
    logic        ppu_ack;
    logic [15:0] cart_address_o;
    logic [7:0]  cart_data_o;
    logic        cart_write_o, cart_request_o;
    logic [7:0]  cart_data;
    logic        cart_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_bus_controller #(.RAM_ADDRESS_BITS(11), .TIMEOUT_CYCLES(64)) dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .cpu_address_i(cpu_address), .cpu_data_i(cpu_data),
        .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
        .cpu_data_o(cpu_data_o), .cpu_data_valid_o(cpu_data_valid_o),
        .ppu_address_o(ppu_address_o), .ppu_data_o(ppu_data_o),
        .ppu_write_o(ppu_write_o), .ppu_request_o(ppu_request_o),
        .ppu_data_i(ppu_data), .ppu_ack_i(ppu_ack),
        .cart_address_o(cart_address_o), .cart_data_o(cart_data_o),
        .cart_write_o(cart_write_o), .cart_request_o(cart_request_o),
        .cart_data_i(cart_data), .cart_ack_i(cart_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one access starting at the next negedge; ack_k is the edge index (E0 = accept)
    // at which the external ack is sampled, or -1 for no ack.
    task automatic run_access(input logic [15:0] addr, input logic [7:0] wdata, input logic wr,
                              input int ack_k, input logic [7:0] ack_data,
                              output int lat, output logic [7:0] rdata, output int req_cycles,
                              output int width, output logic [15:0] snap_addr,
                              output logic snap_write);
        @(negedge clk);
        cpu_address = addr; cpu_data = wdata; cpu_read = ~wr; cpu_write = wr;
        lat = -1; rdata = 8'h00; req_cycles = 0; width = 0;
        snap_addr = 16'h0; snap_write = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (j == 0) begin
                snap_addr  = ppu_request_o ? {13'h0, ppu_address_o} : cart_address_o;
                snap_write = ppu_write_o | cart_write_o;
            end
            if (ppu_request_o | cart_request_o) req_cycles++;
            if (cpu_data_valid_o) begin
                width++;
                if (lat < 0) begin
                    lat = j; rdata = cpu_data_o;
                    cpu_read = 1'b0; cpu_write = 1'b0;
                end
            end
            if (j == ack_k - 1) begin
                ppu_ack = 1'b1; cart_ack = 1'b1; ppu_data = ack_data; cart_data = ack_data;
            end
            if (j == ack_k) begin
                ppu_ack = 1'b0; cart_ack = 1'b0;
            end
            if (lat >= 0 && j == lat + 2) break;
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    int          lat, reqc, width, vcount;
    logic [7:0]  rd;
    logic [15:0] sa;
    logic        sw;

    initial begin
        rst_n = 1'b0; cpu_address = 16'h0; cpu_data = 8'h0; cpu_read = 1'b0; cpu_write = 1'b0;
        ppu_data = 8'h0; ppu_ack = 1'b0; cart_data = 8'h0; cart_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", {31'h0, cpu_data_valid_o}, 32'h0);
        check_eq("rst_data", {24'h0, cpu_data_o}, 32'h0);
        check_eq("rst_reqs", {30'h0, ppu_request_o, cart_request_o}, 32'h0);
        check_eq("rst_wr", {30'h0, ppu_write_o, cart_write_o}, 32'h0);
        check_eq("rst_cart_addr", {16'h0, cart_address_o}, 32'h0);
        rst_n = 1'b1;

        run_access(16'h0000, 8'h3C, 1'b1, -1, 8'h00, lat, rd, reqc, width, sa, sw);
        check_eq("w0000_lat", lat, 2);
        check_eq("w0000_data", {24'h0, rd}, 32'h3C);

        run_access(16'h0123, 8'h5A, 1'b1, -1, 8'h00, lat, rd, reqc, width, sa, sw);
        check_eq("w0123_lat", lat, 2);
        check_eq("w0123_width", width, 1);
        check_eq("w0123_data", {24'h0, rd}, 32'h5A);

        run_access(16'h0923, 8'h00, 1'b0, -1, 8'h00, lat, rd, reqc, width, sa, sw);
        check_eq("r0923_lat", lat, 2);
        check_eq("r0923_width", width, 1);
        check_eq("r0923_data", {24'h0, rd}, 32'h5A);
        check_eq("r0923_noreq", reqc, 0);

        run_access(16'h2002, 8'h00, 1'b0, 3, 8'h80, lat, rd, reqc, width, sa, sw);
        check_eq("ppu_idx", {16'h0, sa}, 32'h2);
        check_eq("ppu_wr", {31'h0, sw}, 32'h0);
        check_eq("ppu_req_cycles", reqc, 3);
        check_eq("ppu_lat", lat, 4);
        check_eq("ppu_data", {24'h0, rd}, 32'h80);

        run_access(16'h8000, 8'h00, 1'b0, -1, 8'h00, lat, rd, reqc, width, sa, sw);
        check_eq("tmo_req_cycles", reqc, 64);
        check_eq("tmo_lat", lat, 65);
        check_eq("tmo_data", {24'h0, rd}, 32'h80);

        run_access(16'h4016, 8'h00, 1'b0, -1, 8'h00, lat, rd, reqc, width, sa, sw);
        check_eq("io_rd_lat", lat, 2);
        check_eq("io_rd_data", {24'h0, rd}, 32'h80);
        check_eq("io_rd_noreq", reqc, 0);

        run_access(16'h4016, 8'h11, 1'b1, -1, 8'h00, lat, rd, reqc, width, sa, sw);
        check_eq("io_wr_lat", lat, 2);
        check_eq("io_wr_noreq", reqc, 0);

        run_access(16'hC000, 8'h77, 1'b1, 2, 8'hEE, lat, rd, reqc, width, sa, sw);
        check_eq("cart_wr_addr", {16'h0, sa}, 32'hC000);
        check_eq("cart_wr_flag", {31'h0, sw}, 32'h1);
        check_eq("cart_wr_lat", lat, 3);
        check_eq("cart_wr_data", {24'h0, rd}, 32'h77);

        // Held request: valid once, then re-accept after one low cycle.
        @(negedge clk);
        cpu_address = 16'h0923; cpu_read = 1'b1; vcount = 0; lat = -1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (cpu_data_valid_o) begin vcount++; if (lat < 0) lat = j; end
        end
        check_eq("held_single", vcount, 1);
        check_eq("held_lat", lat, 2);
        cpu_read = 1'b0;
        @(negedge clk);
        cpu_read = 1'b1; lat = -1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (cpu_data_valid_o && lat < 0) begin lat = j; rd = cpu_data_o; cpu_read = 1'b0; end
        end
        cpu_read = 1'b0;
        check_eq("rearm_lat", lat, 2);
        check_eq("rearm_data", {24'h0, rd}, 32'h5A);

        // Reset in the middle of a cartridge wait.
        @(negedge clk);
        cpu_address = 16'h8000; cpu_read = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_mid_req_before", {31'h0, cart_request_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_req_after", {31'h0, cart_request_o}, 32'h0);
        cpu_read = 1'b0; vcount = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (cpu_data_valid_o) vcount++;
        end
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (cpu_data_valid_o) vcount++;
        end
        check_eq("rst_mid_novalid", vcount, 0);

        run_access(16'h0000, 8'h00, 1'b0, -1, 8'h00, lat, rd, reqc, width, sa, sw);
        check_eq("post_rst_lat", lat, 2);
        check_eq("post_rst_data", {24'h0, rd}, 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
